// File: rtl/ro_sampler.sv
// Ring-oscillator sampler: synchronises the RO outputs, XOR-combines them into
// one raw bit, samples that bit at a divided rate, removes bias with a von
// Neumann corrector and packs the surviving bits into words for a valid/ready
// consumer. It also steps the RO length controls and flags a stuck source.
module ro_sampler #(
    parameter int N_RO       = 4,
    parameter int SAMPLE_DIV = 16,
    parameter int WORD_W     = 8,
    parameter int STUCK_LIM  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N_RO-1:0]   ro_in,
    output logic [N_RO-1:0]   ro_ctrl,
    output logic [WORD_W-1:0] rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              ovf,
    output logic              err_stuck
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int RUN_W = $clog2(STUCK_LIM + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
    localparam logic [RUN_W-1:0] RUN_LIM  = RUN_W'(STUCK_LIM);

    typedef enum logic {
        P0 = 1'b0,
        P1 = 1'b1
    } vn_state_e;

    // XOR-combine of all synchronised RO outputs.
    function automatic logic xor_reduce(input logic [N_RO-1:0] v);
        return ^v;
    endfunction

    vn_state_e         state_q, state_d;
    logic [N_RO-1:0]   sync1_q, sync2_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              b0_q, b0_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic [N_RO-1:0]   ctrl_q, ctrl_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              last_raw_q, last_raw_d;
    logic              stuck_q, stuck_d;

    logic              raw_s;
    logic              strobe_s;
    logic              emit_s;
    logic              emit_bit_s;
    logic              word_done_s;
    logic [WORD_W-1:0] word_s;

    assign raw_s = xor_reduce(sync2_q);

    // Sample divider and von Neumann pair FSM; disabling restarts both.
    always_comb begin
        div_d      = div_q;
        state_d    = state_q;
        b0_d       = b0_q;
        emit_s     = 1'b0;
        emit_bit_s = 1'b0;
        strobe_s   = en && (div_q == DIV_LAST);
        if (!en) begin
            div_d   = '0;
            state_d = P0;
        end else begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
            if (strobe_s) begin
                case (state_q)
                    P0: begin
                        b0_d    = raw_s;
                        state_d = P1;
                    end
                    P1: begin
                        emit_s     = (b0_q != raw_s);
                        emit_bit_s = b0_q;
                        state_d    = P0;
                    end
                    default: begin
                        state_d = P0;
                    end
                endcase
            end else begin
                state_d = state_q;
            end
        end
    end

    // Bit packing, word hand-off to the consumer, overflow and RO control step.
    always_comb begin
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        ovf_d       = ovf_q;
        ctrl_d      = ctrl_q;
        word_s      = {shreg_q[WORD_W-2:0], emit_bit_s};
        word_done_s = emit_s && (bit_cnt_q == BIT_LAST);
        if (!en) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
        end else if (emit_s) begin
            shreg_d = word_s;
            if (word_done_s) begin
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
        end else begin
            shreg_d = shreg_q;
        end
        // A word completing while the consumer takes the old one replaces it.
        if (word_done_s) begin
            if (!valid_q || rnd_ready) begin
                data_d  = word_s;
                valid_d = 1'b1;
                ctrl_d  = ctrl_q + N_RO'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && rnd_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Run-length of identical raw samples; a zero count marks the first strobe.
    always_comb begin
        run_d      = run_q;
        last_raw_d = last_raw_q;
        stuck_d    = stuck_q;
        if (!en) begin
            run_d   = '0;
            stuck_d = 1'b0;
        end else if (strobe_s) begin
            last_raw_d = raw_s;
            if ((run_q == '0) || (raw_s != last_raw_q)) begin
                run_d = RUN_W'(1);
            end else if (run_q < RUN_LIM) begin
                run_d = run_q + RUN_W'(1);
            end else begin
                run_d = run_q;
            end
            if (run_d == RUN_LIM) begin
                stuck_d = 1'b1;
            end else begin
                stuck_d = stuck_q;
            end
        end else begin
            run_d = run_q;
        end
    end

    // State registers; synchronous reset clears everything including the synchronisers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            div_q      <= '0;
            state_q    <= P0;
            b0_q       <= 1'b0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            ctrl_q     <= '0;
            run_q      <= '0;
            last_raw_q <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            sync1_q    <= ro_in;
            sync2_q    <= sync1_q;
            div_q      <= div_d;
            state_q    <= state_d;
            b0_q       <= b0_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            ctrl_q     <= ctrl_d;
            run_q      <= run_d;
            last_raw_q <= last_raw_d;
            stuck_q    <= stuck_d;
        end
    end

    assign ro_ctrl   = ctrl_q;
    assign rnd_data  = data_q;
    assign rnd_valid = valid_q;
    assign ovf       = ovf_q;
    assign err_stuck = stuck_q;

endmodule

// File: doc/ro_sampler.md
Name: ro_sampler

Overview:
Digitises the free-running outputs of the TRNG's ring oscillators into whitened random words. Each RO output is synchronised and the outputs are XOR-combined into one raw bit, which is sampled at a divided clock rate. The raw stream is debiased with a von Neumann corrector and packed into words. Words are presented on a valid/ready interface to the downstream consumer (FIFO/UART). The block also drives the RO ctrl inputs, to perturb oscillator lengths, and reports a stuck-source health flag.

Parameters:
N_RO, 4, number of ring oscillators sampled (>=1)
SAMPLE_DIV, 16, clk cycles between sample strobes (>=2)
WORD_W, 8, output word width (>=2)
STUCK_LIM, 64, consecutive identical raw samples that raise err_stuck (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
en  in  1  sampling enable
ro_in  in  N_RO  asynchronous RO outputs
ro_ctrl  out  N_RO  RO length-select controls, one per RO
rnd_data  out  WORD_W  random word
rnd_valid  out  1  rnd_data valid
rnd_ready  in  1  consumer accepts the word
ovf  out  1  sticky: a completed word was dropped
err_stuck  out  1  sticky: raw stream stuck

Behaviour:
- Reset (rst_n low at a clk edge) takes priority over everything, including mid-word or mid-handshake. Reset clears all state and all outputs to 0, including the synchronisers. There is no partial-word carry-over.
- Synchronisation: each ro_in bit passes through 2 flops. raw = XOR of all second-stage flops. Latency from ro_in to raw is 2 cycles.
- Divider: div_cnt counts 0..SAMPLE_DIV-1 while en=1, then wraps to 0. strobe = en && div_cnt==SAMPLE_DIV-1. The first strobe occurs on the SAMPLE_DIV-th cycle with en=1.
- Von Neumann FSM, states P0 and P1:
  - P0 + strobe: b0 <= raw, go to P1.
  - P1 + strobe: if b0 != raw, emit bit b0; otherwise emit nothing. Go to P0.
- Packing: on each emitted bit, shreg <= {shreg[WORD_W-2:0], bit} and bit_cnt increments. The first emitted bit ends up at the MSB.
- Word completion: when the WORD_W-th bit is emitted, bit_cnt returns to 0 and the word is complete.
  - If rnd_valid==0, or rnd_ready==1 in that same cycle: load rnd_data and set rnd_valid=1 on the next edge.
  - If rnd_valid==1 and rnd_ready==0: discard the new word, keep rnd_data unchanged, and set ovf=1.
- Handshake: transfer occurs when rnd_valid && rnd_ready. After a transfer, rnd_valid drops on the next edge unless a word completes in the same cycle.
  - rnd_data must be stable while rnd_valid=1 and rnd_ready=0.
  - rnd_valid never drops without a transfer, except on reset.
- ro_ctrl: binary counter, incremented on each loaded word (not on dropped words). Wraps modulo 2^N_RO.
- Stuck detector: on each strobe, if raw == last_raw then run_cnt increments (saturating at STUCK_LIM), else run_cnt resets to 1. last_raw <= raw. The first strobe after reset or enable sets run_cnt=1. err_stuck is set when run_cnt reaches STUCK_LIM and is sticky.
- en=0, applied on the next edge:
  - div_cnt, FSM (to P0), bit_cnt, shreg, run_cnt and err_stuck are cleared.
  - rnd_data, rnd_valid and ovf are held, and handshakes still complete.
  - Synchronisers keep running.
  - ovf clears only on reset.

Test Plan:
1. Reset mid-word: run until bit_cnt=5, then assert rst_n=0 for 1 cycle. Required: all outputs 0. Next, with en=1 held from release, the first strobe occurs after exactly SAMPLE_DIV cycles and the first word needs 8 fresh emitted bits.
2. Debias/pack: hold the XOR of ro_in per strobe to the raw pair sequence (1,0),(0,1) repeated 4 times, with rnd_ready=1. Required: rnd_data=0xAA and rnd_valid high for 1 cycle. Then feed pairs (1,1),(0,0) for 8 pairs. Required: no rnd_valid.
3. Backpressure: rnd_ready=0 while two words complete (0xAA then 0x55). Required: rnd_data stays 0xAA, ovf=1, ro_ctrl=1. Then raise rnd_ready for 1 cycle. Required: rnd_valid drops and ovf stays 1.
4. Simultaneous completion: rnd_valid=1 holding 0xAA, and rnd_ready=1 in the same cycle that 0x55 completes. Required: next cycle rnd_data=0x55, rnd_valid=1, ovf=0, ro_ctrl=2.
5. Stuck source: hold ro_in constant. Required: err_stuck rises on the 64th strobe (cycle 64*SAMPLE_DIV + 2 after en) and no rnd_valid appears. Then drop en for 1 cycle. Required: err_stuck=0.
6. Disable hold: en=0 while rnd_valid=1 and rnd_ready=0. Required: rnd_data and rnd_valid are held, no strobes occur, and bit_cnt=0. Re-enable. Required: the first strobe occurs after SAMPLE_DIV cycles.
